// File: rtl/pe_channel_packer.sv
// Packs OUT_CHANNEL serial channel beats into one wide pixel and queues pixels in a 2-entry FIFO.
// Optional sticky drop indicator: define PE_CHANNEL_PACKER_OVERFLOW_FLAG_EN to add the overflow output.
module pe_channel_packer #(
    parameter  int DATA_WIDTH  = 16,
    parameter  int OUT_CHANNEL = 32,
    localparam int CW          = $clog2(OUT_CHANNEL),
    localparam int PW          = DATA_WIDTH * OUT_CHANNEL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic [PW-1:0]         o_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic                  stall,
`ifdef PE_CHANNEL_PACKER_OVERFLOW_FLAG_EN
    output logic                  overflow,
`endif
    output logic [CW-1:0]         ch_idx
);

    localparam logic [CW-1:0] LAST_CH = CW'(OUT_CHANNEL - 1);

    logic [CW-1:0] ch_cnt_q, ch_cnt_d;
    logic [PW-1:0] asm_q, asm_d;
    logic [PW-1:0] mem_q [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          o_valid_q, o_valid_d;
    logic          stall_q, stall_d;

    logic          last_beat;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic [PW-1:0] pixel;

    assign last_beat = i_valid && (ch_cnt_q == LAST_CH);
    assign pop       = o_valid_q && o_ready;
    assign push_ok   = last_beat && ((count_q != 2'd2) || pop);
    assign drop      = last_beat && (count_q == 2'd2) && !pop;

    // The final channel bypasses the assembly register so the pixel is pushed on its own beat.
    assign pixel = {i_data, asm_q[PW-DATA_WIDTH-1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < OUT_CHANNEL; gi++) begin : g_slot
            assign asm_d[gi*DATA_WIDTH +: DATA_WIDTH] =
                (i_valid && (ch_cnt_q == CW'(gi))) ? i_data : asm_q[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        ch_cnt_d = ch_cnt_q;
        if (i_valid) begin
            ch_cnt_d = (ch_cnt_q == LAST_CH) ? '0 : ch_cnt_q + 1'b1;
        end

        wr_ptr_d = wr_ptr_q ^ push_ok;
        rd_ptr_d = rd_ptr_q ^ pop;

        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        o_valid_d = (count_d != 2'd0);
        stall_d   = (count_d == 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt_q  <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            o_valid_q <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            ch_cnt_q  <= ch_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            o_valid_q <= o_valid_d;
            stall_q   <= stall_d;
        end
    end

    // Data storage is deliberately left out of reset; only the control state is cleared.
    always_ff @(posedge clk) begin
        asm_q <= asm_d;
        if (push_ok) begin
            mem_q[wr_ptr_q] <= pixel;
        end
    end

`ifdef PE_CHANNEL_PACKER_OVERFLOW_FLAG_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

    assign o_data  = mem_q[rd_ptr_q];
    assign o_valid = o_valid_q;
    assign stall   = stall_q;
    assign ch_idx  = ch_cnt_q;

endmodule

// File: tb/tb_pe_channel_packer.sv
// Randomized and directed bench for pe_channel_packer against a queue-based pixel model.
module tb_pe_channel_packer;

    localparam int DW = 16;
    localparam int OC = 4;
    localparam int PW = DW * OC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_valid = 1'b0;
    logic          o_ready = 1'b0;
    logic [PW-1:0] o_data;
    logic          o_valid;
    logic          stall;
    logic [1:0]    ch_idx;
`ifdef PE_CHANNEL_PACKER_OVERFLOW_FLAG_EN
    logic          overflow;
`endif

    pe_channel_packer #(
        .DATA_WIDTH (DW),
        .OUT_CHANNEL(OC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .stall   (stall),
`ifdef PE_CHANNEL_PACKER_OVERFLOW_FLAG_EN
        .overflow(overflow),
`endif
        .ch_idx  (ch_idx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: list of queued pixels, beats of the pixel in progress, sticky drop flag.
    logic [PW-1:0] q_m[$];
    logic [DW-1:0] beats_m[OC];
    int            ch_m  = 0;
    bit            ovf_m = 1'b0;

    task automatic check_val(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check_val("o_valid", PW'(o_valid), PW'(q_m.size() != 0));
        check_val("stall", PW'(stall), PW'(q_m.size() == 2));
        check_val("ch_idx", PW'(ch_idx), PW'(ch_m));
        if (q_m.size() != 0) check_val("o_data", o_data, q_m[0]);
`ifdef PE_CHANNEL_PACKER_OVERFLOW_FLAG_EN
        check_val("overflow", PW'(overflow), PW'(ovf_m));
`endif
    endtask

    // Called at a falling edge: check current outputs, drive inputs, advance model one cycle.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        int            sz;
        bit            pop;
        logic [PW-1:0] pix;
        check_outputs();
        i_valid = v;
        i_data  = d;
        o_ready = r;
        sz  = q_m.size();
        pop = (sz != 0) && r;
        if (pop) begin
            $display("[TB] pop pixel %016h", q_m[0]);
            void'(q_m.pop_front());
        end
        if (v) begin
            beats_m[ch_m] = d;
            if (ch_m == OC - 1) begin
                pix = '0;
                for (int i = 0; i < OC; i++) pix[i*DW +: DW] = beats_m[i];
                if (sz < 2 || pop) q_m.push_back(pix);
                else begin
                    ovf_m = 1'b1;
                    $display("[TB] drop pixel %016h", pix);
                end
            end
            ch_m = (ch_m + 1) % OC;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_pixel(input logic [DW-1:0] base, input logic r);
        for (int i = 0; i < OC; i++) step(1'b1, base + DW'(i), r);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b0;
        #1;
        check_val("rst_ch_idx", PW'(ch_idx), '0);
        check_val("rst_o_valid", PW'(o_valid), '0);
        check_val("rst_stall", PW'(stall), '0);
        q_m.delete();
        ch_m  = 0;
        ovf_m = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        do_reset();

        // Back-to-back beats with downstream ready.
        send_pixel(16'h0001, 1'b1);
        check_val("basic_data", o_data, 64'h0004_0003_0002_0001);
        check_val("basic_valid", PW'(o_valid), PW'(1));
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Two pixels queued, then drained in order.
        send_pixel(16'h0010, 1'b0);
        send_pixel(16'h0020, 1'b0);
        check_val("full_stall", PW'(stall), PW'(1));
        check_val("full_head", o_data, 64'h0013_0012_0011_0010);
        step(1'b0, '0, 1'b1);
        check_val("drain_b", o_data, 64'h0023_0022_0021_0020);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Push coincides with a pop while full.
        send_pixel(16'h0030, 1'b0);
        send_pixel(16'h0040, 1'b0);
        for (int i = 0; i < OC - 1; i++) step(1'b1, 16'h0050 + DW'(i), 1'b0);
        step(1'b1, 16'h0053, 1'b1);
        check_val("swap_head", o_data, 64'h0043_0042_0041_0040);
        step(1'b0, '0, 1'b1);
        check_val("swap_next", o_data, 64'h0053_0052_0051_0050);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Push while full with no pop: pixel is dropped.
        send_pixel(16'h0060, 1'b0);
        send_pixel(16'h0070, 1'b0);
        send_pixel(16'h0080, 1'b0);
        check_val("drop_head", o_data, 64'h0063_0062_0061_0060);
        check_val("drop_ch_idx", PW'(ch_idx), '0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        check_val("drop_next", o_data, 64'h0073_0072_0071_0070);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Reset in the middle of a pixel.
        step(1'b1, 16'h0001, 1'b1);
        step(1'b1, 16'h0002, 1'b1);
        do_reset();
        send_pixel(16'h000A, 1'b1);
        check_val("mid_rst_data", o_data, 64'h000D_000C_000B_000A);
        step(1'b0, '0, 1'b1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            else step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 1) == 1);
        end
        step(1'b0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_channel_packer.md
PE_CHANNEL_PACKER -- requirements
Module: pe_channel_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of one channel value.
REQ-002 SHALL have parameter OUT_CHANNEL, default 32: channels per output pixel; must be >= 2.
REQ-003 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port i_data, input, DATA_WIDTH bits: one channel result from the PE datapath.
REQ-006 SHALL have port i_valid, input, 1 bit: i_data is valid this cycle; no backpressure on this side.
REQ-007 SHALL have port o_data, output, DATA_WIDTH*OUT_CHANNEL bits: packed pixel at the FIFO head.
REQ-008 SHALL have port o_valid, output, 1 bit: FIFO non-empty.
REQ-009 SHALL have port o_ready, input, 1 bit: downstream accepts o_data when o_valid && o_ready.
REQ-010 SHALL have port stall, output, 1 bit: upstream must not start a new pixel while high.
REQ-011 SHALL have port ch_idx, output, clog2(OUT_CHANNEL) bits: channel index the next i_valid beat is written to.

Function
REQ-012 SHALL keep channel counter ch_cnt (= ch_idx); each i_valid beat writes i_data into assembly-register slot ch_cnt, bits [ch_cnt*DATA_WIDTH +: DATA_WIDTH]; channel 0 is in the LSBs.
REQ-013 SHALL increment ch_cnt on each i_valid beat and wrap from OUT_CHANNEL-1 to 0.
REQ-014 SHALL, on the beat with ch_cnt == OUT_CHANNEL-1, push the complete pixel into a 2-entry FIFO in the same cycle, with the last channel merged directly from i_data and no extra bubble.
REQ-015 SHALL make a pushed pixel visible on o_data/o_valid on the cycle after the push edge (1-cycle latency from the last beat).
REQ-016 SHALL pop the FIFO head on a cycle where o_valid && o_ready, and present the next entry on the following cycle.
REQ-017 SHALL hold o_data stable while o_valid && !o_ready.
REQ-018 SHALL accept a push and a pop in the same cycle at any occupancy; occupancy is unchanged and no data is lost.
REQ-019 SHALL drop the pixel if it is pushed while the FIFO holds 2 entries and no pop occurs that cycle; FIFO contents are unchanged and ch_cnt still wraps to 0.
REQ-020 SHALL drive stall = (occupancy == 2), registered with no combinational path from o_ready.
REQ-021 SHALL leave partial assembly-register slots holding stale data; only completed pixels are ever output.

Reset
REQ-022 SHALL, on rst_n low, asynchronously clear ch_cnt to 0, FIFO occupancy and pointers to 0, o_valid to 0, and stall to 0.
REQ-023 SHALL NOT reset the assembly register or FIFO data storage; o_data is don't-care while o_valid=0.
REQ-024 SHALL discard a partially assembled pixel when reset is asserted mid-pixel; after release, assembly restarts at channel 0.

Configuration
REQ-025 SHALL, with macro PE_CHANNEL_PACKER_OVERFLOW_FLAG_EN defined, add output overflow (1 bit): sticky, set on the cycle after any REQ-019 drop, cleared only by reset.
REQ-026 SHALL, without PE_CHANNEL_PACKER_OVERFLOW_FLAG_EN, have no overflow port or logic; drops are silent.

Verification
REQ-027 SHALL cover: OUT_CHANNEL=4, o_ready=1, beats 0x0001..0x0004 back-to-back -> one cycle after the 4th beat, o_valid=1 and o_data=0x0004_0003_0002_0001, popped the same cycle.
REQ-028 SHALL cover: o_ready=0, two full pixels (A, B) streamed -> stall=1 after B; raise o_ready -> A then B on consecutive cycles, after which stall=0 and o_valid=0.
REQ-029 SHALL cover: FIFO full, third pixel C's last beat coincides with o_ready=1 -> A popped, C accepted, output order B then C, no overflow.
REQ-030 SHALL cover: FIFO full, o_ready=0, third pixel pushed -> pixel dropped, A and B intact, and overflow=1 when PE_CHANNEL_PACKER_OVERFLOW_FLAG_EN is defined.
REQ-031 SHALL cover: rst_n pulsed low after 2 of 4 beats -> ch_idx=0, o_valid=0; the next 4 beats 0x0A..0x0D yield o_data=0x000D_000C_000B_000A.
